// File: rtl/pe_mvm_scheduler_pkg.sv
// ============================================================================
// pe_mvm_scheduler_pkg : state encoding, PE task codes and PE latency default
// Revision: 1.0
// ============================================================================
`default_nettype none

package pe_mvm_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_OUT   = 2'd3
  } state_t;

  // Task codes shared with the PE; only TASK_MVM is ever driven here
  localparam logic [1:0] TASK_MVM   = 2'b00;
  localparam logic [1:0] TASK_RSVD1 = 2'b01;
  localparam logic [1:0] TASK_RSVD2 = 2'b10;
  localparam logic [1:0] TASK_RSVD3 = 2'b11;

  localparam int PE_LAT_DEFAULT = 2;

endpackage

`default_nettype wire

// File: rtl/pe_acc_unit.sv
// ============================================================================
// pe_acc_unit : fetch-tag delay line and sign-extending row accumulator
// Optional macro PE_MVM_SAT_EN: saturating add with sticky sat flag
// Revision: 1.0
// ============================================================================
`default_nettype none

module pe_acc_unit #(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 24,
  parameter int DEPTH      = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tag_in,
  input  logic [DATA_WIDTH-1:0] pe_result,
  input  logic                  clear,
  output logic                  tag_out,
  output logic [ACC_WIDTH-1:0]  acc
`ifdef PE_MVM_SAT_EN
  ,
  output logic                  sat
`endif
);

  logic [DEPTH-1:0]            tag_sr;
  logic signed [ACC_WIDTH-1:0] ext;
  logic [ACC_WIDTH-1:0]        nxt;

  assign ext     = ACC_WIDTH'($signed(pe_result));
  assign tag_out = tag_sr[DEPTH-1];

`ifdef PE_MVM_SAT_EN
  logic [ACC_WIDTH:0] sum;
  logic               ovf;

  // One guard bit: overflow when the two top bits disagree
  assign sum = {acc[ACC_WIDTH-1], acc} + {ext[ACC_WIDTH-1], ext};
  assign ovf = sum[ACC_WIDTH] ^ sum[ACC_WIDTH-1];
  assign nxt = !ovf ? sum[ACC_WIDTH-1:0] :
               sum[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}} :
                                {1'b0, {(ACC_WIDTH-1){1'b1}}};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sat <= 1'b0;
    end else if (clear) begin
      sat <= 1'b0;
    end else if (tag_out && ovf) begin
      sat <= 1'b1;
    end
  end
`else
  assign nxt = acc + ext;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tag_sr <= '0;
      acc    <= '0;
    end else begin
      tag_sr <= (tag_sr << 1) | DEPTH'(tag_in);
      if (clear) begin
        acc <= '0;
      end else if (tag_out) begin
        acc <= nxt;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/pe_mvm_scheduler.sv
// ============================================================================
// pe_mvm_scheduler : drives one PE through y = W*x, one row result per handshake
// Optional macro PE_MVM_SAT_EN: saturating accumulation plus y_sat output
// Revision: 1.0
// ============================================================================
`default_nettype none

module pe_mvm_scheduler
  import pe_mvm_scheduler_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_MACS   = 4,
  parameter int ROW_W      = 8,
  parameter int TILE_W     = 8,
  parameter int ACC_WIDTH  = 24,
  parameter int RD_LAT     = 1,
  parameter int PE_LAT     = PE_LAT_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ROW_W-1:0]      num_rows,
  input  logic [TILE_W-1:0]     num_tiles,
  output logic                  busy,
  output logic                  done,
  output logic                  rd_en,
  output logic [ROW_W-1:0]      rd_row,
  output logic [TILE_W-1:0]     rd_tile,
  output logic [1:0]            pe_task_ctrl,
  output logic                  pe_rst_acc,
  input  logic [DATA_WIDTH-1:0] pe_result,
  output logic                  y_valid,
  input  logic                  y_ready,
  output logic [ACC_WIDTH-1:0]  y_data,
  output logic [ROW_W-1:0]      y_row
`ifdef PE_MVM_SAT_EN
  ,
  output logic                  y_sat
`endif
);

  localparam int DEPTH = RD_LAT + PE_LAT;
  localparam int DCW   = $clog2(DEPTH) + 1;

  if (NUM_MACS < 1 || ACC_WIDTH < DATA_WIDTH || DEPTH < 1) begin : g_param_check
    $error("pe_mvm_scheduler: illegal parameter combination");
  end

  state_t              state;
  logic [ROW_W-1:0]    rows_q;
  logic [TILE_W-1:0]   tiles_q;
  logic [DCW-1:0]      drain_cnt;
  logic                tag_out;
  logic                acc_clear;

  assign busy         = (state != ST_IDLE);
  assign pe_task_ctrl = TASK_MVM;
  assign pe_rst_acc   = ~tag_out;
  assign y_row        = rd_row;
  assign acc_clear    = (state == ST_OUT) && y_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      rows_q    <= '0;
      tiles_q   <= '0;
      drain_cnt <= '0;
      rd_en     <= 1'b0;
      rd_row    <= '0;
      rd_tile   <= '0;
      y_valid   <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (num_rows == '0 || num_tiles == '0) begin
              done <= 1'b1;
            end else begin
              rows_q  <= num_rows;
              tiles_q <= num_tiles;
              rd_row  <= '0;
              rd_tile <= '0;
              rd_en   <= 1'b1;
              state   <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: begin
          if (rd_tile == tiles_q - TILE_W'(1)) begin
            rd_en     <= 1'b0;
            drain_cnt <= '0;
            state     <= ST_DRAIN;
          end else begin
            rd_tile <= rd_tile + TILE_W'(1);
          end
        end
        // Last tile lands in acc at the end of drain cycle DEPTH-1
        ST_DRAIN: begin
          if (drain_cnt == DCW'(DEPTH - 1)) begin
            y_valid <= 1'b1;
            state   <= ST_OUT;
          end else begin
            drain_cnt <= drain_cnt + DCW'(1);
          end
        end
        ST_OUT: begin
          if (y_ready) begin
            y_valid <= 1'b0;
            if (rd_row == rows_q - ROW_W'(1)) begin
              done  <= 1'b1;
              state <= ST_IDLE;
            end else begin
              rd_row  <= rd_row + ROW_W'(1);
              rd_tile <= '0;
              rd_en   <= 1'b1;
              state   <= ST_ISSUE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  pe_acc_unit #(
    .DATA_WIDTH (DATA_WIDTH),
    .ACC_WIDTH  (ACC_WIDTH),
    .DEPTH      (DEPTH)
  ) u_acc (
    .clk        (clk),
    .rst        (rst),
    .tag_in     (rd_en),
    .pe_result  (pe_result),
    .clear      (acc_clear),
    .tag_out    (tag_out),
    .acc        (y_data)
`ifdef PE_MVM_SAT_EN
    ,
    .sat        (y_sat)
`endif
  );

endmodule

`default_nettype wire

// File: tb/tb_pe_mvm_scheduler.sv
// ============================================================================
// tb_pe_mvm_scheduler : directed vectors for pe_mvm_scheduler (ACC_WIDTH=8)
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_pe_mvm_scheduler;

`ifdef PE_MVM_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_b = 1'b0;
  logic       start = 1'b0;
  logic [7:0] num_rows = 8'd0;
  logic [7:0] num_tiles = 8'd0;
  logic       busy, done, rd_en, pe_rst_acc, y_valid;
  logic       y_ready = 1'b0;
  logic [7:0] rd_row, rd_tile, y_data, y_row, pe_result;
  logic [1:0] pe_task_ctrl;
`ifdef PE_MVM_SAT_EN
  logic       y_sat;
`endif

  always #5 clk = ~clk;

  pe_mvm_scheduler #(
    .DATA_WIDTH(8), .NUM_MACS(4), .ROW_W(8), .TILE_W(8),
    .ACC_WIDTH(8), .RD_LAT(1), .PE_LAT(2)
  ) dut (
    .clk(clk), .rst(rst_b), .start(start), .num_rows(num_rows),
    .num_tiles(num_tiles), .busy(busy), .done(done), .rd_en(rd_en),
    .rd_row(rd_row), .rd_tile(rd_tile), .pe_task_ctrl(pe_task_ctrl),
    .pe_rst_acc(pe_rst_acc), .pe_result(pe_result), .y_valid(y_valid),
    .y_ready(y_ready), .y_data(y_data), .y_row(y_row)
`ifdef PE_MVM_SAT_EN
    , .y_sat(y_sat)
`endif
  );

  // PE model: value for (row, tile) appears 3 cycles after its rd_en
  logic [7:0] mdl [2][8];
  logic [7:0] vpipe [3];
  logic [2:0] tpipe;

  always @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      tpipe <= 3'b000;
    end else begin
      tpipe <= {tpipe[1:0], rd_en};
    end
    vpipe[0] <= (rd_en && rd_row < 8'd2 && rd_tile < 8'd8) ? mdl[rd_row[0]][rd_tile[2:0]] : 8'h55;
    vpipe[1] <= vpipe[0];
    vpipe[2] <= vpipe[1];
  end
  assign pe_result = vpipe[2];

  typedef struct {
    logic [7:0] rows;
    logic [7:0] tiles;
    logic [7:0] v0 [8];
    logic [7:0] v1 [8];
    logic [7:0] e0;
    logic [7:0] e1;
    logic       s0;
    logic       s1;
  } vec_t;

  vec_t tbl [5];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic run_job(input int vi, input bit poke);
    int cyc, rdc, first, last, bad;
    mdl[0]    = tbl[vi].v0;
    mdl[1]    = tbl[vi].v1;
    num_rows  = tbl[vi].rows;
    num_tiles = tbl[vi].tiles;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int r = 0; r < int'(tbl[vi].rows); r++) begin
      cyc = 0; rdc = 0; first = -1; last = -1; bad = 0;
      while (!y_valid && cyc < 200) begin
        if (rd_en) begin
          if (first < 0) first = cyc;
          last = cyc;
          if (rd_tile !== rdc[7:0] || rd_row !== r[7:0]) bad++;
          rdc++;
        end
        if (pe_rst_acc !== ~tpipe[2] || pe_task_ctrl !== 2'b00 || busy !== 1'b1) bad++;
        if (poke && r == 0 && cyc == 1) begin
          start = 1'b1; num_rows = 8'd5;
        end else begin
          start = 1'b0;
        end
        @(negedge clk);
        cyc++;
      end
      chk("row_latency", cyc, int'(tbl[vi].tiles) + 3);
      chk("rd_en_count", rdc, int'(tbl[vi].tiles));
      chk("rd_en_first", first, 0);
      chk("rd_en_last", last, int'(tbl[vi].tiles) - 1);
      chk("row_ctl", bad, 0);
      chk("y_data", y_data, (r == 0) ? tbl[vi].e0 : tbl[vi].e1);
      chk("y_row", y_row, r);
`ifdef PE_MVM_SAT_EN
      chk("y_sat", y_sat, (r == 0) ? tbl[vi].s0 : tbl[vi].s1);
`endif
      y_ready = 1'b1;
      @(negedge clk);
      y_ready = 1'b0;
    end
    chk("done_pulse", done, 1'b1);
    @(negedge clk);
    chk("done_clear_idle", {done, busy, y_valid}, 3'b000);
  endtask

  initial begin
    int bad, cyc;
    for (int i = 0; i < 5; i++) begin
      tbl[i].v0 = '{default: 8'h00};
      tbl[i].v1 = '{default: 8'h00};
      tbl[i].s0 = 1'b0;
      tbl[i].s1 = 1'b0;
    end
    tbl[0].rows = 8'd2; tbl[0].tiles = 8'd3;
    tbl[0].v0[0] = 8'h05; tbl[0].v0[1] = 8'hFE; tbl[0].v0[2] = 8'h07;
    tbl[0].v1[0] = 8'h01; tbl[0].v1[1] = 8'h01; tbl[0].v1[2] = 8'h01;
    tbl[0].e0 = 8'h0A; tbl[0].e1 = 8'h03;
    tbl[1].rows = 8'd1; tbl[1].tiles = 8'd1;
    tbl[1].v0[0] = 8'hFD; tbl[1].e0 = 8'hFD; tbl[1].e1 = 8'h00;
    tbl[2].rows = 8'd2; tbl[2].tiles = 8'd8;
    tbl[2].v0 = '{default: 8'h7F}; tbl[2].v1 = '{default: 8'h80};
    tbl[2].e0 = SAT ? 8'h7F : 8'hF8; tbl[2].e1 = SAT ? 8'h80 : 8'h00;
    tbl[2].s0 = 1'b1; tbl[2].s1 = 1'b1;
    tbl[3].rows = 8'd1; tbl[3].tiles = 8'd4;
    tbl[3].v0[0] = 8'h64; tbl[3].v0[1] = 8'h64; tbl[3].v0[2] = 8'hCE; tbl[3].v0[3] = 8'hC4;
    tbl[3].e0 = SAT ? 8'h11 : 8'h5A; tbl[3].e1 = 8'h00; tbl[3].s0 = 1'b1;
    tbl[4].rows = 8'd2; tbl[4].tiles = 8'd2;
    tbl[4].v0[0] = 8'hFF; tbl[4].v0[1] = 8'hFF;
    tbl[4].v1[0] = 8'h00; tbl[4].v1[1] = 8'h03;
    tbl[4].e0 = 8'hFE; tbl[4].e1 = 8'h03;
    mdl[0] = tbl[0].v0;
    mdl[1] = tbl[0].v1;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_ctl", {busy, done, rd_en, y_valid, pe_rst_acc, pe_task_ctrl}, 7'b0000100);
    chk("rst_data", {rd_row, rd_tile, y_data, y_row}, 32'h0);
    rst_b = 1'b1;
    @(negedge clk);

    for (int v = 0; v < 5; v++) run_job(v, 1'b0);

    // Start while busy is ignored: job still produces exactly two rows
    run_job(0, 1'b1);
    repeat (3) @(negedge clk);
    chk("busy_start_ignored", {busy, rd_en}, 2'b00);

    // Output held through a 10-cycle y_ready stall
    mdl[0][0] = 8'h09; num_rows = 8'd1; num_tiles = 8'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0; cyc = 0;
    while (!y_valid && cyc < 50) begin @(negedge clk); cyc++; end
    chk("stall_valid_seen", y_valid, 1'b1);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (y_valid !== 1'b1 || y_data !== 8'h09 || y_row !== 8'h00 || rd_en !== 1'b0 || done !== 1'b0) bad++;
      @(negedge clk);
    end
    chk("stall_hold", bad, 0);
    y_ready = 1'b1;
    @(negedge clk);
    y_ready = 1'b0;
    chk("stall_done", {done, y_valid}, 2'b10);

    // Zero tiles / zero rows: done next cycle, nothing else moves
    num_rows = 8'd3; num_tiles = 8'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("zero_tiles_done", {done, busy}, 2'b10);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (rd_en !== 1'b0 || y_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) bad++;
    end
    chk("zero_tiles_quiet", bad, 0);
    num_rows = 8'd0; num_tiles = 8'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("zero_rows_done", {done, busy, rd_en}, 3'b100);
    @(negedge clk);

    // Asynchronous reset during the second ISSUE cycle of a 4-tile job
    mdl[0] = '{default: 8'h32}; num_rows = 8'd1; num_tiles = 8'd4; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("pre_rst_issue", {rd_en, rd_tile}, 9'h101);
    #2 rst_b = 1'b0;
    #1;
    chk("async_rst_ctl", {busy, done, rd_en, y_valid, pe_rst_acc, pe_task_ctrl}, 7'b0000100);
    chk("async_rst_data", {rd_row, rd_tile, y_data, y_row}, 32'h0);
    @(negedge clk);
    rst_b = 1'b1;
    @(negedge clk);
    run_job(4, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
